add_key_inv_mix: RTL and testbench

Decryption round tail that sits directly downstream of the registered inverse-SubBytes stage. It XORs the 128-bit round key into the incoming state, then applies InvMixColumns one 32-bit column per cycle. A per-transfer `in_last` flag bypasses InvMixColumns for the final round. Input and output use valid/ready handshakes, so the round controller can stall or feed it freely.

---
 rtl/add_key_inv_mix.sv | 142 ++++++++++++++
 tb/tb_add_key_inv_mix.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/add_key_inv_mix.sv
// Decryption round tail: AddRoundKey followed by InvMixColumns, one column per cycle.
// A final-round transfer skips the column pass and is presented one cycle after accept.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a transfer; the accept loads w = data ^ key
// MIX   | column col of w is replaced by InvMixColumn(column)
// DONE  | w is presented on out_data until downstream takes it
module add_key_inv_mix (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MIX  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [1:0]   r_col;
    logic [1:0]   w_col_nxt;
    logic [127:0] r_w;
    logic [127:0] w_w_nxt;
    logic [31:0]  w_col_in;
    logic [31:0]  w_col_out;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Each coefficient (0e/0b/0d/09) is a sum of the a, 2a, 4a, 8a terms.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] p2 [4];
        logic [7:0] p4 [4];
        logic [7:0] p8 [4];
        logic [31:0] res;
        logic [1:0] i1;
        logic [1:0] i2;
        logic [1:0] i3;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[31-8*r -: 8];
            p2[r] = xtime(a[r]);
            p4[r] = xtime(p2[r]);
            p8[r] = xtime(p4[r]);
        end
        for (int r = 0; r < 4; r++) begin
            i1 = 2'(r + 1);
            i2 = 2'(r + 2);
            i3 = 2'(r + 3);
            res[31-8*r -: 8] = (p8[r]  ^ p4[r]  ^ p2[r])
                             ^ (p8[i1] ^ p2[i1] ^ a[i1])
                             ^ (p8[i2] ^ p4[i2] ^ a[i2])
                             ^ (p8[i3] ^ a[i3]);
        end
        return res;
    endfunction

    always_comb begin
        w_col_in = r_w[127:96];
        case (r_col)
            2'd0: w_col_in = r_w[127:96];
            2'd1: w_col_in = r_w[95:64];
            2'd2: w_col_in = r_w[63:32];
            2'd3: w_col_in = r_w[31:0];
            default: w_col_in = r_w[127:96];
        endcase
    end

    assign w_col_out = inv_mix_col(w_col_in);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_col   <= 2'd0;
            r_w     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_w     <= w_w_nxt;
        end
    end

    // Handshake outputs decode registered state only, so no input reaches them combinationally.
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_w_nxt     = r_w;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_w_nxt = in_data ^ in_key;
                    if (in_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_col_nxt   = 2'd0;
                        w_state_nxt = S_MIX;
                    end
                end
            end
            S_MIX: begin
                case (r_col)
                    2'd0: w_w_nxt[127:96] = w_col_out;
                    2'd1: w_w_nxt[95:64]  = w_col_out;
                    2'd2: w_w_nxt[63:32]  = w_col_out;
                    2'd3: w_w_nxt[31:0]   = w_col_out;
                    default: w_w_nxt = r_w;
                endcase
                w_col_nxt = r_col + 2'd1;
                if (r_col == 2'd3) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign out_data = r_w;

endmodule

// File: tb/tb_add_key_inv_mix.sv
// Directed plus randomized checks of add_key_inv_mix against a byte-level GF(2^8) model.
module tb_add_key_inv_mix;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [127:0] K = 128'h000102030405060708090a0b0c0d0e0f;

    always #5 clk = ~clk;

    add_key_inv_mix dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d, input logic [127:0] k,
                                           input logic last);
        logic [7:0]   s [16];
        logic [127:0] res;
        logic [127:0] x;
        x = d ^ k;
        for (int i = 0; i < 16; i++) s[i] = x[127-8*i -: 8];
        res = x;
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) begin
                    res[127-8*(4*c+r) -: 8] = gf_mul(8'h0e, s[4*c + r])
                                            ^ gf_mul(8'h0b, s[4*c + (r+1)%4])
                                            ^ gf_mul(8'h0d, s[4*c + (r+2)%4])
                                            ^ gf_mul(8'h09, s[4*c + (r+3)%4]);
                end
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transfer: accept, measure latency, hold under backpressure, then drain.
    task automatic xfer(input logic [127:0] d, input logic [127:0] k, input logic last,
                        input int bp, input logic [127:0] exp, input string tag);
        int lat;
        int exp_lat;
        exp_lat = last ? 1 : 5;
        chk({tag, "_in_ready_idle"}, 128'(in_ready), 128'(1));
        in_valid  = 1'b1;
        in_data   = d;
        in_key    = k;
        in_last   = last;
        out_ready = (bp == 0);
        step();
        lat = 1;
        // Upstream keeps presenting junk; the block must ignore it until it is idle again.
        in_data = rand128();
        in_key  = rand128();
        in_last = $urandom_range(0, 1) == 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            chk({tag, "_in_ready_busy"}, 128'(in_ready), 128'(0));
            step();
            lat++;
        end
        chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
        chk({tag, "_data"}, out_data, exp);
        chk({tag, "_in_ready_done"}, 128'(in_ready), 128'(0));
        for (int i = 0; i < bp; i++) begin
            step();
            chk({tag, "_bp_valid"}, 128'(out_valid), 128'(1));
            chk({tag, "_bp_data"}, out_data, exp);
            chk({tag, "_bp_in_ready"}, 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk({tag, "_drain_valid"}, 128'(out_valid), 128'(0));
        chk({tag, "_drain_in_ready"}, 128'(in_ready), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d;
        logic [127:0] k;
        logic         l;
        int           seen;

        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = rand128();
        in_key    = rand128();
        in_last   = 1'b1;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", out_data, 128'h0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step();
        chk("rst_release_valid", 128'(out_valid), 128'(0));

        xfer({4{32'h8e4da1bc}}, 128'h0, 1'b0, 0, {4{32'hdb135345}}, "vec_imc");

        d = 128'h9fdc589d_01010101_c6c6c6c6_4d7ebdf8 ^ K;
        xfer(d, K, 1'b0, 0, 128'hf20a225c_01010101_c6c6c6c6_2d26314c, "vec_mixkey");

        xfer({16{8'hff}}, 128'h0f0e0d0c0b0a09080706050403020100, 1'b1, 0,
             128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, "vec_last");

        d = rand128();
        k = rand128();
        xfer(d, k, 1'b0, 10, model(d, k, 1'b0), "bp_normal");

        // Reset at E2 of a normal round must discard it.
        in_valid = 1'b1;
        in_data  = rand128();
        in_key   = rand128();
        in_last  = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_in_ready", 128'(in_ready), 128'(1));
        chk("midrst_out_data", out_data, 128'h0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid !== 1'b0) seen++;
            step();
        end
        chk("midrst_no_valid", 128'(seen), 128'(0));
        d = rand128();
        k = rand128();
        xfer(d, k, 1'b0, 0, model(d, k, 1'b0), "midrst_fresh");

        for (int n = 0; n < 40; n++) begin
            d = rand128();
            k = rand128();
            l = ($urandom_range(0, 3) == 0);
            xfer(d, k, l, int'($urandom_range(0, 3)), model(d, k, l), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
